// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR coefficient loader.
package fir_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_SETTLE = 2'd3
    } state_e;

    // Low bit of tap k inside a flat tap vector: tap k occupies [k*tw +: tw].
    function automatic int unsigned tap_lo(input int unsigned k, input int unsigned tw);
        return k * tw;
    endfunction

endpackage

// File: rtl/coef_bank.sv
// Shadow coefficient register file with indexed write and single-cycle copy-out.
module coef_bank
    import fir_pkg::*;
#(
    parameter int unsigned NTAPS = 128,
    parameter int unsigned TW    = 16,
    localparam int unsigned IW   = $clog2(NTAPS)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wr_en,
    input  logic [IW-1:0]         i_wr_idx,
    input  logic [TW-1:0]         i_wr_data,
    input  logic                  i_commit,
    output logic [NTAPS*TW-1:0]   o_taps
);

    logic [TW-1:0] shadow_q [NTAPS];
    logic [TW-1:0] taps_q   [NTAPS];

    // Shadow write port and parallel commit into the active set.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < int'(NTAPS); k++) begin
                shadow_q[k] <= '0;
                taps_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < int'(NTAPS); k++) begin
                if (i_wr_en && (i_wr_idx == IW'(k))) begin
                    shadow_q[k] <= i_wr_data;
                end
            end
            if (i_commit) begin
                taps_q <= shadow_q;
            end
        end
    end

    // Flatten the active set; tap 0 sits in the least significant slice.
    for (genvar k = 0; k < int'(NTAPS); k++) begin : g_pack
        assign o_taps[tap_lo(k, TW) +: TW] = taps_q[k];
    end

endmodule

// File: rtl/fir_coef_loader.sv
// Coefficient load/commit controller: streams a set into a shadow bank,
// commits it atomically, optionally clears the taps, then tracks settling.
module fir_coef_loader
    import fir_pkg::*;
#(
    parameter int unsigned NTAPS           = 128,
    parameter int unsigned TW              = 16,
    parameter int unsigned SETTLE          = NTAPS + 2,
    parameter bit          CLEAR_ON_COMMIT = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_ce,
    input  logic                  i_start,
    input  logic                  i_coef_valid,
    input  logic [TW-1:0]         i_coef,
    output logic                  o_coef_ready,
    output logic [NTAPS*TW-1:0]   o_taps,
    output logic                  o_fir_reset,
    output logic                  o_busy,
    output logic                  o_settled,
    output logic                  o_done
);

    localparam int unsigned IW = $clog2(NTAPS);
    localparam int unsigned SW = $clog2(SETTLE + 1);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic          fir_reset_q, fir_reset_d;
    logic          busy_q, busy_d;
    logic          settled_q, settled_d;
    logic          done_q, done_d;
    logic          wr_en_c;
    logic          commit_c;

    coef_bank #(
        .NTAPS (NTAPS),
        .TW    (TW)
    ) u_bank (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_wr_en   (wr_en_c),
        .i_wr_idx  (idx_q),
        .i_wr_data (i_coef),
        .i_commit  (commit_c),
        .o_taps    (o_taps)
    );

    // State, counters and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            fir_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            settled_q   <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            fir_reset_q <= fir_reset_d;
            busy_q      <= busy_d;
            settled_q   <= settled_d;
            done_q      <= done_d;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        ready_d     = 1'b0;
        fir_reset_d = 1'b0;
        settled_d   = settled_q;
        done_d      = 1'b0;
        wr_en_c     = 1'b0;
        commit_c    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                    ready_d = 1'b1;
                end
            end

            ST_LOAD: begin
                ready_d = 1'b1;
                if (i_start) begin
                    // Restart wins over a coincident word.
                    idx_d = '0;
                end else if (i_coef_valid && ready_q) begin
                    wr_en_c = 1'b1;
                    if (idx_q == IW'(NTAPS - 1)) begin
                        state_d = ST_COMMIT;
                        ready_d = 1'b0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end

            ST_COMMIT: begin
                commit_c    = 1'b1;
                fir_reset_d = CLEAR_ON_COMMIT;
                settled_d   = 1'b0;
                cnt_d       = '0;
                state_d     = ST_SETTLE;
            end

            ST_SETTLE: begin
                if (i_start) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                    ready_d = 1'b1;
                end else if (i_ce && !fir_reset_q) begin
                    // The clear-pulse cycle does not count toward settling.
                    if (cnt_q == SW'(SETTLE - 1)) begin
                        cnt_d     = SW'(SETTLE);
                        state_d   = ST_IDLE;
                        settled_d = 1'b1;
                        done_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + SW'(1);
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign o_coef_ready = ready_q;
    assign o_fir_reset  = fir_reset_q;
    assign o_busy       = busy_q;
    assign o_settled    = settled_q;
    assign o_done       = done_q;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader with NTAPS=4, TW=16, SETTLE=6.
module tb_fir_coef_loader;

    localparam int unsigned NTAPS = 4;
    localparam int unsigned TW    = 16;
    localparam int unsigned TAPW  = NTAPS * TW;

    logic            i_clk = 1'b0;
    logic            i_reset;
    logic            i_ce;
    logic            i_start;
    logic            i_coef_valid;
    logic [TW-1:0]   i_coef;
    logic            o_coef_ready;
    logic [TAPW-1:0] o_taps;
    logic            o_fir_reset;
    logic            o_busy;
    logic            o_settled;
    logic            o_done;

    int checks   = 0;
    int failures = 0;
    int done_pulses = 0;

    fir_coef_loader #(
        .NTAPS           (NTAPS),
        .TW              (TW),
        .SETTLE          (6),
        .CLEAR_ON_COMMIT (1'b1)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_ce         (i_ce),
        .i_start      (i_start),
        .i_coef_valid (i_coef_valid),
        .i_coef       (i_coef),
        .o_coef_ready (o_coef_ready),
        .o_taps       (o_taps),
        .o_fir_reset  (o_fir_reset),
        .o_busy       (o_busy),
        .o_settled    (o_settled),
        .o_done       (o_done)
    );

    always #5 i_clk = ~i_clk;

    // Count done pulses independently of the directed waits.
    always @(negedge i_clk) if (o_done === 1'b1) done_pulses++;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Stream four words back to back, tap 0 first.
    task automatic load_set(input logic [63:0] set);
        for (int k = 0; k < 4; k++) begin
            i_coef_valid = 1'b1;
            i_coef       = set[k*16 +: 16];
            tick();
        end
        i_coef_valid = 1'b0;
        i_coef       = '0;
    endtask

    // Tick until o_done, returning the number of ticks taken (-1 on timeout).
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (o_done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    localparam logic [63:0] SET_A = 64'h0004_0003_0002_0001;
    localparam logic [63:0] SET_B = 64'h0044_0033_0022_0011;
    localparam logic [63:0] SET_C = 64'h00B4_00B3_00B2_00B1;
    localparam logic [63:0] SET_D = 64'h00C4_00C3_00C2_00C1;
    localparam logic [63:0] SET_E = 64'h00D4_00D3_00D2_00D1;
    localparam logic [63:0] SET_F = 64'h00E4_00E3_00E2_00E1;
    localparam logic [63:0] SET_G = 64'h00F4_00F3_00F2_00F1;

    initial begin
        int n;
        int base;
        int done_at;
        logic [63:0] gapw;

        i_reset = 1'b1; i_ce = 1'b0; i_start = 1'b0; i_coef_valid = 1'b0; i_coef = '0;
        tick(); tick();
        i_reset = 1'b0;
        check_eq("rst_taps",    64'(o_taps), 64'h0);
        check_eq("rst_settled", 64'(o_settled), 64'h1);
        check_eq("rst_ready",   64'(o_coef_ready), 64'h0);
        check_eq("rst_busy",    64'(o_busy), 64'h0);
        check_eq("rst_firrst",  64'(o_fir_reset), 64'h0);
        check_eq("rst_done",    64'(o_done), 64'h0);

        // Basic load with continuous i_ce.
        i_ce = 1'b1;
        i_coef_valid = 1'b1; i_coef = 16'h7777;
        tick();
        check_eq("idle_ignores_valid", 64'(o_coef_ready), 64'h0);
        i_coef_valid = 1'b0;
        i_start = 1'b1; tick(); i_start = 1'b0;
        check_eq("a_ready_after_start", 64'(o_coef_ready), 64'h1);
        check_eq("a_busy", 64'(o_busy), 64'h1);
        load_set(SET_A);
        check_eq("a_ready_drops", 64'(o_coef_ready), 64'h0);
        check_eq("a_taps_before_commit", 64'(o_taps), 64'h0);
        tick();
        check_eq("a_taps_commit", 64'(o_taps), SET_A);
        check_eq("a_firrst_pulse", 64'(o_fir_reset), 64'h1);
        check_eq("a_settled_low", 64'(o_settled), 64'h0);
        tick();
        check_eq("a_firrst_clear", 64'(o_fir_reset), 64'h0);
        wait_done(n);
        check_eq("a_done_latency", 64'(n + 1), 64'd7);
        check_eq("a_settled_high", 64'(o_settled), 64'h1);
        check_eq("a_busy_idle", 64'(o_busy), 64'h0);
        tick();
        check_eq("a_done_one_cycle", 64'(o_done), 64'h0);

        // Gapped valid: only handshakes advance the index.
        i_start = 1'b1; tick(); i_start = 1'b0;
        gapw = SET_B;
        for (int k = 0; k < 4; k++) begin
            i_coef_valid = 1'b1; i_coef = gapw[k*16 +: 16];
            tick();
            i_coef_valid = 1'b0; i_coef = 16'hDEAD;
            tick();
            if (k == 2) check_eq("b_taps_hold_old", 64'(o_taps), SET_A);
        end
        i_coef = '0;
        check_eq("b_taps_commit", 64'(o_taps), SET_B);
        wait_done(n);
        check_eq("b_done_latency", 64'(n), 64'd7);

        // Restart mid-load: coincident word is dropped.
        i_start = 1'b1; tick(); i_start = 1'b0;
        i_coef_valid = 1'b1;
        i_coef = 16'h00A1; tick();
        i_coef = 16'h00A2; tick();
        i_start = 1'b1; i_coef = 16'h0BAD; tick(); i_start = 1'b0;
        check_eq("c_ready_after_restart", 64'(o_coef_ready), 64'h1);
        load_set(SET_C);
        tick();
        check_eq("c_taps_commit", 64'(o_taps), SET_C);
        wait_done(n);
        check_eq("c_done_latency", 64'(n), 64'd7);

        // Sparse i_ce; strobe in the clear-pulse cycle is not counted.
        i_ce = 1'b0;
        i_start = 1'b1; tick(); i_start = 1'b0;
        load_set(SET_D);
        tick();
        check_eq("d_firrst_pulse", 64'(o_fir_reset), 64'h1);
        i_ce = 1'b1; tick();
        check_eq("d_settled_low", 64'(o_settled), 64'h0);
        done_at = -1;
        for (int c = 0; c < 40; c++) begin
            i_ce = ((c % 3) == 2);
            tick();
            if (o_done === 1'b1) begin
                done_at = c;
                break;
            end
        end
        i_ce = 1'b1;
        check_eq("d_done_on_6th_strobe", 64'(done_at), 64'd17);
        check_eq("d_settled_high", 64'(o_settled), 64'h1);

        // i_start during SETTLE.
        base = done_pulses;
        i_start = 1'b1; tick(); i_start = 1'b0;
        load_set(SET_E);
        tick(); tick(); tick(); tick();
        i_start = 1'b1; tick(); i_start = 1'b0;
        check_eq("e_ready_reload", 64'(o_coef_ready), 64'h1);
        check_eq("e_settled_stays_low", 64'(o_settled), 64'h0);
        check_eq("e_taps_kept", 64'(o_taps), SET_E);
        load_set(SET_F);
        tick();
        check_eq("e_taps_new", 64'(o_taps), SET_F);
        wait_done(n);
        check_eq("e_done_latency", 64'(n), 64'd7);
        check_eq("e_single_done", 64'(done_pulses - base), 64'd1);

        // Reset mid-LOAD.
        i_start = 1'b1; tick(); i_start = 1'b0;
        i_coef_valid = 1'b1;
        i_coef = 16'h0101; tick();
        i_coef = 16'h0202; tick();
        i_coef_valid = 1'b0;
        i_reset = 1'b1; tick(); i_reset = 1'b0;
        check_eq("rl_taps", 64'(o_taps), 64'h0);
        check_eq("rl_settled", 64'(o_settled), 64'h1);
        check_eq("rl_ready", 64'(o_coef_ready), 64'h0);
        check_eq("rl_busy", 64'(o_busy), 64'h0);

        // Reset mid-SETTLE.
        i_start = 1'b1; tick(); i_start = 1'b0;
        load_set(SET_G);
        tick();
        check_eq("rs_taps_commit", 64'(o_taps), SET_G);
        tick(); tick();
        base = done_pulses;
        i_reset = 1'b1; tick(); i_reset = 1'b0;
        check_eq("rs_taps", 64'(o_taps), 64'h0);
        check_eq("rs_settled", 64'(o_settled), 64'h1);
        check_eq("rs_ready", 64'(o_coef_ready), 64'h0);
        check_eq("rs_busy", 64'(o_busy), 64'h0);
        for (int i = 0; i < 10; i++) tick();
        check_eq("rs_no_done", 64'(done_pulses - base), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
